// File: rtl/conf_int_mul__op_sequencer.sv
// Operand/control sequencer in front of the configurable multiplier wrapper:
// warm-up sweep, operand issue with a fixed settle window, result capture.
// Optional ops_done handshake counter is built when OPSEQ_PERF_CNT_EN is defined.
module conf_int_mul__op_sequencer #(
  parameter int DATA_PATH_BITWIDTH = 24,
  parameter int LAT                = 3,
  parameter int WARM_CYCLES        = 64
) (
  input  logic                          clk,
  input  logic                          rstP,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a_in,
  input  logic [DATA_PATH_BITWIDTH-12:0] b_in,
  input  logic [1:0]                    op_mode,
  output logic [DATA_PATH_BITWIDTH-1:0] A_to_wrapper,
  output logic [DATA_PATH_BITWIDTH-12:0] B_to_wrapper,
  output logic [2:0]                    state_to_wrapper,
  output logic [8:0]                    count0,
  output logic                          acc__sel,
  input  logic [31:0]                   P,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   result
`ifdef OPSEQ_PERF_CNT_EN
  ,
  output logic [15:0]                   ops_done
`endif
);

  localparam int AW = DATA_PATH_BITWIDTH;
  localparam int BW = DATA_PATH_BITWIDTH - 11;
  localparam logic [9:0] WARM_END = 10'(WARM_CYCLES);
  localparam logic [3:0] LAT_LAST = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_WARM,
    S_IDLE,
    S_ISSUE,
    S_OUT
  } fsm_t;

  fsm_t          r_fsm;
  logic [9:0]    r_warm_idx;
  logic [3:0]    r_lat;
  logic          r_in_ready;
  logic [AW-1:0] r_a;
  logic [BW-1:0] r_b;
  logic [2:0]    r_state;
  logic [8:0]    r_count0;
  logic          r_acc_sel;
  logic          r_out_valid;
  logic [31:0]   r_result;

  logic [2:0]    w_mode_state;
  logic          w_mode_acc;

  // Mode 3 is not a distinct mode; it falls through to the accurate mapping.
  always_comb begin
    w_mode_state = 3'b011;
    w_mode_acc   = 1'b1;
    case (op_mode)
      2'd1: begin
        w_mode_state = 3'b100;
        w_mode_acc   = 1'b0;
      end
      2'd2: begin
        w_mode_state = 3'b010;
        w_mode_acc   = 1'b1;
      end
      default: begin
        w_mode_state = 3'b011;
        w_mode_acc   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstP) begin
      r_fsm       <= S_WARM;
      r_warm_idx  <= 10'd0;
      r_lat       <= 4'd0;
      r_in_ready  <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_state     <= 3'b000;
      r_count0    <= 9'd0;
      r_acc_sel   <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
    end else begin
      case (r_fsm)
        S_WARM: begin
          // r_warm_idx runs one past the last sweep index to mark the exit cycle.
          if (r_warm_idx == WARM_END) begin
            r_state    <= 3'b000;
            r_in_ready <= 1'b1;
            r_fsm      <= S_IDLE;
          end else begin
            r_state    <= 3'b001;
            r_count0   <= r_warm_idx[8:0];
            r_warm_idx <= r_warm_idx + 10'd1;
          end
        end
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_state    <= w_mode_state;
            r_acc_sel  <= w_mode_acc;
            r_in_ready <= 1'b0;
            r_lat      <= LAT_LAST;
            r_fsm      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_lat == 4'd0) begin
            r_result    <= P;
            r_out_valid <= 1'b1;
            r_state     <= 3'b000;
            r_acc_sel   <= 1'b1;
            r_fsm       <= S_OUT;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= S_IDLE;
          end
        end
        default: r_fsm <= S_WARM;
      endcase
    end
  end

`ifdef OPSEQ_PERF_CNT_EN
  logic [15:0] r_ops_done;

  always_ff @(posedge clk) begin
    if (rstP) begin
      r_ops_done <= 16'd0;
    end else if (r_out_valid && out_ready) begin
      r_ops_done <= r_ops_done + 16'd1;
    end
  end

  assign ops_done = r_ops_done;
`endif

  assign in_ready         = r_in_ready;
  assign A_to_wrapper     = r_a;
  assign B_to_wrapper     = r_b;
  assign state_to_wrapper = r_state;
  assign count0           = r_count0;
  assign acc__sel         = r_acc_sel;
  assign out_valid        = r_out_valid;
  assign result           = r_result;

endmodule

// File: tb/tb_conf_int_mul__op_sequencer.sv
// Directed bench for conf_int_mul__op_sequencer: a cycle-level reference model
// checked every negedge, plus literal expectations at key points.
module tb_conf_int_mul__op_sequencer;

  localparam int DW   = 24;
  localparam int BWD  = DW - 11;
  localparam int LAT  = 3;
  localparam int WARM = 64;

  logic            clk = 1'b0;
  logic            rstP = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   a_in = '0;
  logic [BWD-1:0]  b_in = '0;
  logic [1:0]      op_mode = 2'd0;
  logic [DW-1:0]   A_to_wrapper;
  logic [BWD-1:0]  B_to_wrapper;
  logic [2:0]      state_to_wrapper;
  logic [8:0]      count0;
  logic            acc__sel;
  logic [31:0]     P;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     result;
`ifdef OPSEQ_PERF_CNT_EN
  logic [15:0]     ops_done;
`endif

  logic [31:0]     p_val = 32'd0;
  bit              p_ramp = 1'b0;
  assign P = p_val;

  int n_vec = 0;
  int n_err = 0;

  conf_int_mul__op_sequencer #(
    .DATA_PATH_BITWIDTH(DW),
    .LAT(LAT),
    .WARM_CYCLES(WARM)
  ) dut (
    .clk(clk),
    .rstP(rstP),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_in(a_in),
    .b_in(b_in),
    .op_mode(op_mode),
    .A_to_wrapper(A_to_wrapper),
    .B_to_wrapper(B_to_wrapper),
    .state_to_wrapper(state_to_wrapper),
    .count0(count0),
    .acc__sel(acc__sel),
    .P(P),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result)
`ifdef OPSEQ_PERF_CNT_EN
    ,
    .ops_done(ops_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] mode_state(input logic [1:0] m);
    if (m == 2'd1) return 3'b100;
    if (m == 2'd2) return 3'b010;
    return 3'b011;
  endfunction

  // Reference model: k = clean edges since reset, then one operation at a time.
  int             k = 0;
  int             j = 0;
  bit             started = 1'b0;
  bit             m_busy = 1'b0;
  bit             m_out = 1'b0;
  logic [1:0]     m_mode = 2'd0;
  logic [DW-1:0]  m_a = '0;
  logic [BWD-1:0] m_b = '0;
  logic [31:0]    m_res = '0;
  logic [15:0]    m_ops = '0;

  always @(posedge clk) begin
    bit idle;
    started = 1'b1;
    if (rstP) begin
      k = 0; j = 0; m_busy = 0; m_out = 0; m_mode = 0;
      m_a = '0; m_b = '0; m_res = '0; m_ops = '0;
    end else begin
      idle = (k >= WARM + 1) && !m_busy && !m_out;
      if (m_out) begin
        if (out_ready) begin
          m_out = 0;
          m_ops = m_ops + 16'd1;
        end
      end else if (m_busy) begin
        j++;
        if (j == LAT) begin
          m_res  = P;
          m_busy = 0;
          m_out  = 1;
        end
      end else if (idle && in_valid) begin
        m_busy = 1; j = 0;
        m_a = a_in; m_b = b_in; m_mode = op_mode;
      end
      if (k < 100000) k++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'((k >= WARM + 1) && !m_busy && !m_out));
      chk("state", 32'(state_to_wrapper),
          (k == 0) ? 32'd0 : (k <= WARM) ? 32'd1 : m_busy ? 32'(mode_state(m_mode)) : 32'd0);
      chk("count0", 32'(count0),
          (k == 0) ? 32'd0 : (k <= WARM) ? 32'(k - 1) : 32'(WARM - 1));
      chk("acc_sel", 32'(acc__sel), m_busy ? 32'(m_mode != 2'd1) : 32'd1);
      chk("A", 32'(A_to_wrapper), 32'(m_a));
      chk("B", 32'(B_to_wrapper), 32'(m_b));
      chk("out_valid", 32'(out_valid), 32'(m_out));
      chk("result", result, m_res);
`ifdef OPSEQ_PERF_CNT_EN
      chk("ops_done", 32'(ops_done), 32'(m_ops));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (p_ramp) p_val = p_val + 32'h01010101;
  endtask

  task automatic warmup();
    tick();
    chk("lit_warm_first_count0", 32'(count0), 32'd0);
    chk("lit_warm_first_state", 32'(state_to_wrapper), 32'd1);
    repeat (WARM - 1) tick();
    chk("lit_warm_last_count0", 32'(count0), 32'd63);
    chk("lit_warm_last_state", 32'(state_to_wrapper), 32'd1);
    tick();
    chk("lit_idle_state", 32'(state_to_wrapper), 32'd0);
    chk("lit_idle_in_ready", 32'(in_ready), 32'd1);
    chk("lit_idle_count0", 32'(count0), 32'd63);
  endtask

  // One operation: accept, LAT scrambled ISSUE cycles, result, handshake.
  task automatic do_op(input logic [DW-1:0] a, input logic [BWD-1:0] b, input logic [1:0] m,
                       input logic [31:0] p, input logic [2:0] exp_st, input logic exp_acc);
    in_valid = 1'b1; a_in = a; b_in = b; op_mode = m; p_val = p;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < LAT; c++) begin
      chk("lit_issue_state", 32'(state_to_wrapper), 32'(exp_st));
      chk("lit_issue_acc", 32'(acc__sel), 32'(exp_acc));
      chk("lit_issue_A", 32'(A_to_wrapper), 32'(a));
      a_in = DW'($urandom); b_in = BWD'($urandom); op_mode = 2'($urandom);
      tick();
    end
    chk("lit_out_valid", 32'(out_valid), 32'd1);
    if (!p_ramp) chk("lit_result", result, p);
    chk("lit_out_acc", 32'(acc__sel), 32'd1);
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("lit_rst_acc", 32'(acc__sel), 32'd1);
    chk("lit_rst_in_ready", 32'(in_ready), 32'd0);
    rstP = 1'b0;
    warmup();

    do_op(24'h000100, 13'h0004, 2'd0, 32'h12345678, 3'b011, 1'b1);
    chk("lit_back_idle", 32'(in_ready), 32'd1);
    do_op(24'hFFFF00, 13'h1FFC, 2'd1, 32'hCAFEF00D, 3'b100, 1'b0);
    do_op(24'h7FFFFF, 13'h0FFF, 2'd2, 32'h00000001, 3'b010, 1'b1);
    do_op(24'h800000, 13'h1000, 2'd3, 32'hFFFFFFFF, 3'b011, 1'b1);
    p_ramp = 1'b1;
    do_op(24'h0A0B0C, 13'h0123, 2'd1, 32'h10000000, 3'b100, 1'b0);
    p_ramp = 1'b0;

    // Back-pressure: hold result for 10 cycles while a stray request is offered.
    out_ready = 1'b0;
    in_valid = 1'b1; a_in = 24'h00ABCD; b_in = 13'h0055; op_mode = 2'd2; p_val = 32'h0BADCAFE;
    tick();
    in_valid = 1'b0;
    repeat (LAT) tick();
    p_ramp = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; a_in = DW'($urandom);
      chk("lit_bp_valid", 32'(out_valid), 32'd1);
      chk("lit_bp_result", result, 32'h0BADCAFE);
      chk("lit_bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    p_ramp = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("lit_bp_release", 32'(in_ready), 32'd1);
    chk("lit_bp_valid_low", 32'(out_valid), 32'd0);

    // Reset during the second ISSUE cycle.
    in_valid = 1'b1; a_in = 24'h123456; b_in = 13'h0321; op_mode = 2'd0; p_val = 32'h55AA55AA;
    tick();
    in_valid = 1'b0;
    tick();
    rstP = 1'b1;
    tick();
    rstP = 1'b0;
    chk("lit_midrst_valid", 32'(out_valid), 32'd0);
    chk("lit_midrst_state", 32'(state_to_wrapper), 32'd0);
    chk("lit_midrst_A", 32'(A_to_wrapper), 32'd0);
    chk("lit_midrst_result", result, 32'd0);
    warmup();

    // Back-to-back operations with in_valid held high and a ramping P.
    p_ramp = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      a_in = DW'($urandom); b_in = BWD'($urandom); op_mode = 2'(c);
      tick();
    end
    in_valid = 1'b0;
    p_ramp = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
